// File: rtl/mem_loader_unit_pkg.sv
// Shared constants for mem_loader_unit: word length, the idle instruction
// value driven to the core while it is held off, the loader FSM state
// encoding, and a byte-lane insert helper used when assembling words.
package mem_loader_unit_pkg;

    localparam int          WORD_LEN     = 32;
    localparam logic [31:0] NOP_INST_VAL = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Place byte b into lane 'lane' of word, leaving the other lanes untouched.
    function automatic logic [WORD_LEN-1:0] lane_insert(input logic [WORD_LEN-1:0] word,
                                                        input logic [7:0]          b,
                                                        input logic [1:0]          lane);
        logic [WORD_LEN-1:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_loader_unit_if.sv
// Byte-stream loader channel (valid/ready).
//   ld_valid : byte valid          (master -> slave)
//   ld_data  : byte, little-endian within each word
//   ld_last  : final byte of the image
//   ld_ready : byte accepted when ld_valid & ld_ready (slave -> master)
interface mem_loader_unit_if;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_data;
    logic       ld_last;

    modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
    modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/mem_loader_unit_sp_ram_2r1w.sv
// sp_ram_2r1w: word array with two registered read ports (A, B) and one
// write port. While rd_en is low the read registers load their idle values
// RST_A / RST_B instead of array data. The array itself is never reset.
// Macro MEM_READ_BYPASS_EN: when defined, a read of the index being written
// on the same edge returns the new write data; otherwise the old contents.
// Ports: clk, rst_n, rd_en, ra_idx/ra_data, rb_idx/rb_data, we/w_idx/w_data.
module sp_ram_2r1w
    import mem_loader_unit_pkg::*;
#(
    parameter int                  DEPTH = 4096,
    parameter int                  AW    = $clog2(DEPTH),
    parameter logic [WORD_LEN-1:0] RST_A = 32'h0000_0000,
    parameter logic [WORD_LEN-1:0] RST_B = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [AW-1:0]       ra_idx,
    input  logic [AW-1:0]       rb_idx,
    input  logic                we,
    input  logic [AW-1:0]       w_idx,
    input  logic [WORD_LEN-1:0] w_data,
    output logic [WORD_LEN-1:0] ra_data,
    output logic [WORD_LEN-1:0] rb_data
);

    logic [WORD_LEN-1:0] mem_q [DEPTH];
    logic [WORD_LEN-1:0] ra_q, ra_d;
    logic [WORD_LEN-1:0] rb_q, rb_d;

    // Next read-register values: array data while enabled, idle values otherwise.
    always_comb begin
        ra_d = RST_A;
        rb_d = RST_B;
        if (rd_en) begin
`ifdef MEM_READ_BYPASS_EN
            ra_d = (we && (w_idx == ra_idx)) ? w_data : mem_q[ra_idx];
            rb_d = (we && (w_idx == rb_idx)) ? w_data : mem_q[rb_idx];
`else
            ra_d = mem_q[ra_idx];
            rb_d = mem_q[rb_idx];
`endif
        end else begin
            ra_d = RST_A;
            rb_d = RST_B;
        end
    end

    // Read-port output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_q <= RST_A;
            rb_q <= RST_B;
        end else begin
            ra_q <= ra_d;
            rb_q <= rb_d;
        end
    end

    // Array write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[w_idx] <= w_data;
        end
    end

    assign ra_data = ra_q;
    assign rb_data = rb_q;

endmodule

// File: rtl/mem_loader_unit.sv
// mem_loader_unit: unified instruction/data memory below the core. After
// reset a byte stream fills the memory while the core is held in reset;
// once ld_last is accepted the core is released and the memory serves the
// instruction port (addr_i -> inst) and the data port (addr_d/wen/wdata ->
// rdata), both with one cycle of read latency.
// Ports: clk, rst_n (async, active-low); ld (loader channel, slave);
//   load_done / load_ovf / load_words status; core_rst_n to the core;
//   addr_i/inst instruction port; addr_d/wen/wdata/rdata data port.
// Optional macro MEM_READ_BYPASS_EN: forward write data to same-index reads.
module mem_loader_unit
    import mem_loader_unit_pkg::*;
#(
    parameter int                  MEM_WORDS = 4096,
    parameter int                  IDX_W     = $clog2(MEM_WORDS),
    parameter logic [WORD_LEN-1:0] NOP_INST  = NOP_INST_VAL
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_loader_unit_if.slave    ld,
    output logic                load_done,
    output logic                load_ovf,
    output logic [IDX_W:0]      load_words,
    output logic                core_rst_n,
    input  logic [31:0]         addr_i,
    output logic [WORD_LEN-1:0] inst,
    input  logic [31:0]         addr_d,
    input  logic                wen,
    input  logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] rdata
);

    state_e              state_q, state_d;
    logic                ld_ready_q, ld_ready_d;
    logic                load_done_q, load_done_d;
    logic                load_ovf_q, load_ovf_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic [IDX_W:0]      word_cnt_q, word_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [WORD_LEN-1:0] asm_q, asm_d;

    logic                accept_s;
    logic                full_s;
    logic                ld_we_s;
    logic [WORD_LEN-1:0] ld_word_s;
    logic                run_s;
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_widx_s;
    logic [WORD_LEN-1:0] mem_wdata_s;
    logic                unused_addr_s;

    // Loader FSM next-state, byte assembly and status flags.
    always_comb begin
        state_d      = state_q;
        ld_ready_d   = ld_ready_q;
        load_done_d  = load_done_q;
        load_ovf_d   = load_ovf_q;
        core_rst_n_d = core_rst_n_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        ld_we_s      = 1'b0;
        // Upper lanes of asm_q are always zero here, so this is also the
        // correctly zero-padded word for a short final flush.
        ld_word_s    = lane_insert(asm_q, ld.ld_data, byte_cnt_q);
        accept_s     = ld.ld_valid & ld_ready_q & (state_q == ST_LOAD);
        full_s       = (word_cnt_q == (IDX_W+1)'(MEM_WORDS));

        case (state_q)
            ST_LOAD: begin
                ld_ready_d = 1'b1;
                if (accept_s) begin
                    if (full_s) begin
                        load_ovf_d = 1'b1;
                    end else if ((byte_cnt_q == 2'd3) || ld.ld_last) begin
                        ld_we_s    = 1'b1;
                        word_cnt_d = word_cnt_q + (IDX_W+1)'(1);
                        asm_d      = 32'h0000_0000;
                        byte_cnt_d = 2'd0;
                    end else begin
                        asm_d      = ld_word_s;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                    if (ld.ld_last) begin
                        state_d     = ST_RELEASE;
                        ld_ready_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                ld_ready_d   = 1'b0;
                core_rst_n_d = 1'b1;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                ld_ready_d   = 1'b0;
                core_rst_n_d = 1'b1;
                state_d      = ST_RUN;
            end
            default: begin
                ld_ready_d = 1'b0;
                state_d    = ST_LOAD;
            end
        endcase
    end

    // FSM state, loader counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            ld_ready_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_ovf_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            ld_ready_q   <= ld_ready_d;
            load_done_q  <= load_done_d;
            load_ovf_q   <= load_ovf_d;
            core_rst_n_q <= core_rst_n_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
        end
    end

    // Write-port mux: the loader owns the array until RUN, then the core's data port.
    always_comb begin
        run_s       = (state_q == ST_RUN);
        mem_we_s    = ld_we_s | (run_s & wen);
        mem_widx_s  = word_cnt_q[IDX_W-1:0];
        mem_wdata_s = ld_word_s;
        if (run_s) begin
            mem_widx_s  = addr_d[IDX_W+1:2];
            mem_wdata_s = wdata;
        end else begin
            mem_widx_s  = word_cnt_q[IDX_W-1:0];
            mem_wdata_s = ld_word_s;
        end
    end

    sp_ram_2r1w #(
        .DEPTH (MEM_WORDS),
        .AW    (IDX_W),
        .RST_A (NOP_INST),
        .RST_B (32'h0000_0000)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (run_s),
        .ra_idx  (addr_i[IDX_W+1:2]),
        .rb_idx  (addr_d[IDX_W+1:2]),
        .we      (mem_we_s),
        .w_idx   (mem_widx_s),
        .w_data  (mem_wdata_s),
        .ra_data (inst),
        .rb_data (rdata)
    );

    // Byte-offset and high address bits are don't-care: addresses alias modulo depth.
    assign unused_addr_s = ^{addr_i[31:IDX_W+2], addr_i[1:0], addr_d[31:IDX_W+2], addr_d[1:0]};

    assign ld.ld_ready  = ld_ready_q;
    assign load_done    = load_done_q;
    assign load_ovf     = load_ovf_q;
    assign load_words   = word_cnt_q;
    assign core_rst_n   = core_rst_n_q;

endmodule

// File: tb/tb_mem_loader_unit.sv
// Self-checking bench for mem_loader_unit (MEM_WORDS = 64). Loads byte
// images with random handshake gaps, then drives random and directed core
// traffic; a queue-based scoreboard holds expected inst/rdata values derived
// from a word-array reference model.
module tb_mem_loader_unit;

    localparam int          MW  = 64;
    localparam int          IW  = $clog2(MW);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ei;
        logic [31:0] ed;
        logic        ci;
        logic        cd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        load_done;
    logic        load_ovf;
    logic [IW:0] load_words;
    logic        core_rst_n;
    logic [31:0] addr_i;
    logic [31:0] inst;
    logic [31:0] addr_d;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    mem_loader_unit_if ld_if ();

    mem_loader_unit #(.MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld         (ld_if),
        .load_done  (load_done),
        .load_ovf   (load_ovf),
        .load_words (load_words),
        .core_rst_n (core_rst_n),
        .addr_i     (addr_i),
        .inst       (inst),
        .addr_d     (addr_d),
        .wen        (wen),
        .wdata      (wdata),
        .rdata      (rdata)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl   [MW];
    bit          known [MW];
    logic [7:0]  img   [$];
    exp_t        sb_q  [$];
    exp_t        mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the registered read ports present a result one edge after each issued cycle.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.ci) chk("inst", inst, mon_e.ei);
            if (mon_e.cd) chk("rdata", rdata, mon_e.ed);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ld_ready", 32'(ld_if.ld_ready), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_load_words", 32'(load_words), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_ovf", 32'(load_ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ld_ready_after_rst", 32'(ld_if.ld_ready), 32'd1);
    endtask

    // Stream the first n bytes of img; with_last tags the final byte and checks the handoff.
    task automatic load_img(input int n, input bit with_last);
        bit          acc;
        int          nw;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            ld_if.ld_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ld_if.ld_valid = 1'b1;
            ld_if.ld_data  = img[i];
            ld_if.ld_last  = with_last && (i == n - 1);
            // Core-side writes must be ignored while loading.
            wen    = 1'($urandom);
            wdata  = $urandom;
            addr_d = $urandom;
            addr_i = $urandom;
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                acc = ld_if.ld_ready;
                @(negedge clk);
            end
            if (!acc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ld_handshake: got no accept, expected accept within 20 cycles");
                ld_if.ld_valid = 1'b0;
                wen = 1'b0;
                return;
            end
        end
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
        if (!with_last) begin
            wen = 1'b0;
            return;
        end
        nw = (n + 3) / 4;
        if (nw > MW) nw = MW;
        for (int k = 0; k < nw; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * k + b < n) w = w | (32'(img[4 * k + b]) << (8 * b));
            end
            mdl[k]   = w;
            known[k] = 1'b1;
        end
        chk("load_done", 32'(load_done), 32'd1);
        chk("ld_ready_after_last", 32'(ld_if.ld_ready), 32'd0);
        chk("core_rst_n_release", 32'(core_rst_n), 32'd0);
        chk("load_words", 32'(load_words), 32'(nw));
        chk("load_ovf", 32'(load_ovf), (n > 4 * MW) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("core_rst_n_run", 32'(core_rst_n), 32'd1);
        chk("inst_nop_idle", inst, NOP);
        chk("rdata_zero_idle", rdata, 32'd0);
        wen = 1'b0;
    endtask

    // One core cycle: drive ports, push the expected registered result, update the model.
    task automatic cyc(input logic [31:0] ai, input logic [31:0] ad, input logic we, input logic [31:0] wd);
        int   ii;
        int   di;
        exp_t e;
        addr_i = ai;
        addr_d = ad;
        wen    = we;
        wdata  = wd;
        ii = int'((ai >> 2) % 32'(MW));
        di = int'((ad >> 2) % 32'(MW));
        e.ei = mdl[ii];
        e.ci = known[ii];
        e.ed = mdl[di];
        e.cd = known[di];
`ifdef MEM_READ_BYPASS_EN
        if (we) begin
            if (ii == di) begin
                e.ei = wd;
                e.ci = 1'b1;
            end
            e.ed = wd;
            e.cd = 1'b1;
        end
`endif
        if (we) begin
            mdl[di]   = wd;
            known[di] = 1'b1;
        end
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a = (a & 32'hFFFF_FF03) | (32'(idx) << 2);
        return a;
    endfunction

    task automatic rand_traffic(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            cyc(rand_addr($urandom_range(0, 7)), rand_addr($urandom_range(0, 7)),
                ($urandom_range(0, 9) < 3), $urandom);
        end
        wen = 1'b0;
    endtask

    task automatic set_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    initial begin
        rst_n          = 1'b1;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = 8'h00;
        ld_if.ld_last  = 1'b0;
        addr_i         = 32'h0;
        addr_d         = 32'h0;
        wen            = 1'b0;
        wdata          = 32'h0;
        for (int k = 0; k < MW; k++) begin
            mdl[k]   = 32'h0;
            known[k] = 1'b0;
        end
        @(negedge clk);

        // Two-instruction program image.
        do_reset();
        img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        load_img(8, 1'b1);
        cyc(32'h0, 32'h4, 1'b0, 32'h0);
        cyc(32'h4, 32'h0, 1'b0, 32'h0);

        // Write then read back, byte-offset alias, depth alias, same-edge read/write.
        cyc(32'h0, 32'h40, 1'b1, 32'hDEAD_BEEF);
        cyc(32'h40, 32'h40, 1'b0, 32'h0);
        cyc(32'h0, 32'h43, 1'b0, 32'h0);
        cyc(32'h43, 32'h40 + 32'(4 * MW), 1'b0, 32'h0);
        cyc(32'h40, 32'h40, 1'b1, 32'h1234_5678);
        cyc(32'h40, 32'h40, 1'b0, 32'h0);
        wen = 1'b0;
        rand_traffic(80);

        // Reset after three bytes, then a fresh four-byte image.
        do_reset();
        set_img(3);
        load_img(3, 1'b0);
        do_reset();
        set_img(4);
        load_img(4, 1'b1);
        cyc(32'h0, 32'h1, 1'b0, 32'h0);

        // Six bytes: the second word is zero-padded.
        do_reset();
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load_img(6, 1'b1);
        cyc(32'h4, 32'h4, 1'b0, 32'h0);

        // Single-byte image.
        do_reset();
        set_img(1);
        load_img(1, 1'b1);
        cyc(32'h0, 32'h0, 1'b0, 32'h0);

        // Overflow: one word more than capacity.
        do_reset();
        set_img(4 * MW + 4);
        load_img(4 * MW + 4, 1'b1);
        cyc(32'(4 * (MW - 1)), 32'h0, 1'b0, 32'h0);
        cyc(32'h0, 32'(4 * (MW - 1)), 1'b0, 32'h0);

        // Random-length images followed by random traffic.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            set_img($urandom_range(1, 24));
            load_img(img.size(), 1'b1);
            rand_traffic(20);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
